// File: rtl/f_ifu_pkg.sv
// Shared fetch-stage definitions: reset PC, nop encoding and the
// F/D pipeline bundle carried from fetch into decode.
package f_ifu_pkg;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/f_ifu_if.sv
// Instruction-memory request/response bus.
// master = fetch unit (req, addr out), slave = memory (ready, rdata out).
interface f_ifu_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/f_ibuf.sv
// One-entry instruction response buffer: holds a word returned while
// the pipe is stalled. Ports: capture/rdata in, drain in, ibuf/ibuf_valid out.
module f_ibuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        drain,
    input  logic [31:0] rdata,
    output logic [31:0] ibuf,
    output logic        ibuf_valid
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ibuf       <= '0;
            ibuf_valid <= 1'b0;
        end else if (drain) begin
            ibuf_valid <= 1'b0;
        end else if (capture) begin
            ibuf       <= rdata;
            ibuf_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/f_ifu.sv
// Fetch stage: PC, held branch target and F/D register. Ports: stall/npc
// in, f_pc out, imem master bus, d_instr/d_pc/d_valid out.
module f_ifu
    import f_ifu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    output logic [31:0] f_pc,
    f_ifu_if.master     imem,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic        d_valid
);

    logic [31:0] pc;
    logic [31:0] held_npc;
    logic        held_valid;
    logic [31:0] ibuf;
    logic        ibuf_valid;
    logic        resp;
    logic        have;
    logic        advance;
    logic        bubble;
    logic        capture;
    logic [31:0] word;
    if_id_t      fd;

    // Request is combinational so it drops the moment reset asserts.
    assign imem.imem_req  = reset & ~ibuf_valid;
    assign imem.imem_addr = pc;

    assign resp    = imem.imem_req & imem.imem_ready;
    assign have    = ibuf_valid | resp;
    assign word    = ibuf_valid ? ibuf : imem.imem_rdata;
    assign advance = have & ~stall;
    assign bubble  = ~have & ~stall;
    assign capture = stall & resp;

    f_ibuf u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .capture    (capture),
        .drain      (advance),
        .rdata      (imem.imem_rdata),
        .ibuf       (ibuf),
        .ibuf_valid (ibuf_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= PC_RESET;
            held_npc   <= '0;
            held_valid <= 1'b0;
            fd         <= '0;
        end else if (advance) begin
            fd         <= '{instr: word, pc: pc, valid: 1'b1};
            pc         <= held_valid ? held_npc : npc;
            held_valid <= 1'b0;
        end else if (bubble) begin
            fd <= '{instr: NOP_INSTR, pc: pc, valid: 1'b0};
            // Instruction leaving D may be a branch whose delay slot is
            // still in flight; keep its redirect for the next PC update.
            if (fd.valid && !held_valid) begin
                held_npc   <= npc;
                held_valid <= 1'b1;
            end
        end
    end

    assign f_pc    = pc;
    assign d_instr = fd.instr;
    assign d_pc    = fd.pc;
    assign d_valid = fd.valid;

endmodule
